// File: rtl/branch_predictor_pht.sv
// ---------------------------------------------------------------------------
// branch_predictor_pht
//
// Dynamic branch predictor for the fetch stage. A table of 2^INDEX_BITS
// two-bit saturating counters (the PHT) is indexed by the fetch address,
// optionally combined with a global history register (GHR). The upper bit of
// the selected counter is the predicted direction. The counter is trained
// when the branch resolves in the ALU stage, and a flush is raised in that
// same cycle if the original prediction was wrong.
//
// Optional feature macro: BP_STATS_EN
//   When defined, adds o_branch_count / o_mispredict_count statistics outputs.
//
// Parameters
//   ADDRESS_WIDTH  instruction word address width
//   INDEX_BITS     PHT index width (depth = 2^INDEX_BITS)
//   HIST_BITS      GHR width (<= INDEX_BITS, < INDEX_BITS for gselect)
//   SCHEME         0 bimodal, 1 gshare, 2 gselect, 3 reserved (bimodal)
//   COUNTER_INIT   reset value of every PHT entry
//
// Ports
//   i_Clk               clock, rising edge
//   i_Reset_n           asynchronous active-low reset
//   i_IMEM_address      address of the instruction being fetched
//   i_IMEM_isbranch     fetched instruction is a conditional branch
//   i_Stall             hold prediction outputs
//   i_ALU_isbranch      ALU stage holds a resolving conditional branch
//   i_ALU_outcome       resolved direction (1 = taken)
//   i_ALU_prediction    direction originally predicted for that branch
//   i_ALU_index         PHT index originally used for that branch
//   o_taken             predicted direction (registered)
//   o_valid             prediction refers to a branch (registered)
//   o_index             PHT index used for the prediction (registered)
//   o_flush             misprediction in the ALU stage (combinational)
//   o_branch_count      resolved branches, saturating  (BP_STATS_EN only)
//   o_mispredict_count  mispredictions, saturating     (BP_STATS_EN only)
// ---------------------------------------------------------------------------
module branch_predictor_pht #(
  parameter int          ADDRESS_WIDTH = 22,
  parameter int          INDEX_BITS    = 8,
  parameter int          HIST_BITS     = 8,
  parameter int          SCHEME        = 0,
  parameter logic [1:0]  COUNTER_INIT  = 2'b01
) (
  input  logic                     i_Clk,
  input  logic                     i_Reset_n,
  input  logic [ADDRESS_WIDTH-1:0] i_IMEM_address,
  input  logic                     i_IMEM_isbranch,
  input  logic                     i_Stall,
  input  logic                     i_ALU_isbranch,
  input  logic                     i_ALU_outcome,
  input  logic                     i_ALU_prediction,
  input  logic [INDEX_BITS-1:0]    i_ALU_index,
  output logic                     o_taken,
  output logic                     o_valid,
  output logic [INDEX_BITS-1:0]    o_index,
`ifdef BP_STATS_EN
  output logic [31:0]              o_branch_count,
  output logic [31:0]              o_mispredict_count,
`endif
  output logic                     o_flush
);

  localparam int DEPTH = 1 << INDEX_BITS;

  // Two-bit saturating counter step; never wraps.
  function automatic logic [1:0] sat_update(input logic [1:0] cnt, input logic taken);
    logic [1:0] res;
    if (taken) begin
      res = (cnt == 2'b11) ? cnt : cnt + 2'b01;
    end else begin
      res = (cnt == 2'b00) ? cnt : cnt - 2'b01;
    end
    return res;
  endfunction

  logic [1:0]            r_pht [DEPTH];
  logic [HIST_BITS-1:0]  r_ghr;
  logic                  r_taken;
  logic                  r_valid;
  logic [INDEX_BITS-1:0] r_index;

  logic [INDEX_BITS-1:0] w_index;
  logic [INDEX_BITS-1:0] w_ghr_ext;
  logic [HIST_BITS-1:0]  w_ghr_next;
  logic                  w_flush;
  logic                  w_unused_addr;

  // Only the low address bits feed the index; the rest are intentionally ignored.
  assign w_unused_addr = ^i_IMEM_address;

  assign w_ghr_ext = INDEX_BITS'(r_ghr);

  // Index selection; the GHR used here is always the pre-shift value.
  generate
    if (SCHEME == 1) begin : g_gshare
      assign w_index = i_IMEM_address[INDEX_BITS-1:0] ^ w_ghr_ext;
    end else if (SCHEME == 2) begin : g_gselect
      assign w_index = {i_IMEM_address[INDEX_BITS-HIST_BITS-1:0], r_ghr};
    end else begin : g_bimodal
      assign w_index = i_IMEM_address[INDEX_BITS-1:0];
    end
  endgenerate

  // History shifts in the resolved outcome at the LSB.
  generate
    if (HIST_BITS > 1) begin : g_ghr_wide
      assign w_ghr_next = {r_ghr[HIST_BITS-2:0], i_ALU_outcome};
    end else begin : g_ghr_one
      assign w_ghr_next = i_ALU_outcome;
    end
  endgenerate

  // Flush is held low during reset so a stale ALU stage cannot redirect fetch.
  assign w_flush = i_Reset_n & i_ALU_isbranch & (i_ALU_outcome != i_ALU_prediction);

  // PHT training on resolve; reads in the same cycle see the old value.
  always_ff @(posedge i_Clk or negedge i_Reset_n) begin
    if (!i_Reset_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_pht[i] <= COUNTER_INIT;
      end
    end else if (i_ALU_isbranch) begin
      r_pht[i_ALU_index] <= sat_update(r_pht[i_ALU_index], i_ALU_outcome);
    end
  end

  // Non-speculative global history, advanced only by resolved branches.
  always_ff @(posedge i_Clk or negedge i_Reset_n) begin
    if (!i_Reset_n) begin
      r_ghr <= '0;
    end else if (i_ALU_isbranch) begin
      r_ghr <= w_ghr_next;
    end
  end

  // Prediction registers; frozen while the pipeline is stalled.
  always_ff @(posedge i_Clk or negedge i_Reset_n) begin
    if (!i_Reset_n) begin
      r_taken <= 1'b0;
      r_valid <= 1'b0;
      r_index <= '0;
    end else if (!i_Stall) begin
      r_taken <= r_pht[w_index][1];
      r_valid <= i_IMEM_isbranch;
      r_index <= w_index;
    end
  end

`ifdef BP_STATS_EN
  logic [31:0] r_branch_count;
  logic [31:0] r_mispredict_count;

  // Saturating statistics counters.
  always_ff @(posedge i_Clk or negedge i_Reset_n) begin
    if (!i_Reset_n) begin
      r_branch_count     <= 32'd0;
      r_mispredict_count <= 32'd0;
    end else begin
      if (i_ALU_isbranch && (r_branch_count != 32'hFFFF_FFFF)) begin
        r_branch_count <= r_branch_count + 32'd1;
      end
      if (w_flush && (r_mispredict_count != 32'hFFFF_FFFF)) begin
        r_mispredict_count <= r_mispredict_count + 32'd1;
      end
    end
  end

  assign o_branch_count     = r_branch_count;
  assign o_mispredict_count = r_mispredict_count;
`endif

  assign o_taken = r_taken;
  assign o_valid = r_valid;
  assign o_index = r_index;
  assign o_flush = w_flush;

endmodule
